// File: rtl/leiwand_rv32_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : leiwand_rv32_timer_if
//  Description : Valid/ready data-bus bundle between the core (master) and
//                the timer block (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface leiwand_rv32_timer_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wen;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wen,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wen,
    output mem_ready, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/leiwand_rv32_timer.sv
`default_nettype none
// ============================================================================
//  Module      : leiwand_rv32_timer
//  Description : Memory-mapped prescaled 32-bit timer with compare match
//                (one-shot / auto-reload), sticky W1C pending flag and the
//                core's irq_status output.
//  Revision    : 1.0 - initial release
// ============================================================================
module leiwand_rv32_timer #(
  parameter logic [31:0] BASE_ADDR      = 32'h4000_0000,
  parameter int unsigned PRESCALE_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  leiwand_rv32_timer_if.slave  bus,
  output logic [31:0]          irq_status
);

  // Word index of each register inside the 32-byte window.
  localparam logic [2:0] REG_IRQ      = 3'd0;
  localparam logic [2:0] REG_CTRL     = 3'd1;
  localparam logic [2:0] REG_PRESCALE = 3'd2;
  localparam logic [2:0] REG_COUNT    = 3'd3;
  localparam logic [2:0] REG_COMPARE  = 3'd4;

  // Register state.
  logic                      pending_q, pending_d;
  logic                      enable_q, enable_d;
  logic                      auto_reload_q, auto_reload_d;
  logic                      irq_en_q, irq_en_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [PRESCALE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
  logic [31:0]               count_q, count_d;
  logic [31:0]               compare_q, compare_d;
  logic                      ready_q, ready_d;
  logic [31:0]               rdata_q, rdata_d;

  // Address decode and handshake.
  logic [29:0] word_off;
  logic        in_window;
  logic [2:0]  reg_idx;
  logic        accept;
  logic        wr_en;
  logic        tick;
  logic [31:0] rd_val;
  logic        unused_addr_lsbs;

  // Byte-lane merge of a bus write into an existing register value.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // Offset is computed on word addresses so the byte-offset bits drop out.
  assign word_off         = bus.mem_addr[31:2] - BASE_ADDR[31:2];
  assign in_window        = (word_off[29:3] == 27'd0);
  assign reg_idx          = word_off[2:0];
  assign unused_addr_lsbs = ^bus.mem_addr[1:0];

  // A request is taken only while no acknowledge is outstanding.
  assign accept = bus.mem_valid && in_window && !ready_q;
  assign wr_en  = accept && (bus.mem_wen != 4'b0000);
  assign tick   = enable_q && (pre_cnt_q == prescale_q);

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;
  assign irq_status    = {31'b0, pending_q & irq_en_q};

  // Read mux: current (pre-edge) register contents, unused slots read zero.
  always_comb begin
    rd_val = 32'd0;
    case (reg_idx)
      REG_IRQ:      rd_val = {31'b0, pending_q};
      REG_CTRL:     rd_val = {29'b0, irq_en_q, auto_reload_q, enable_q};
      REG_PRESCALE: rd_val = 32'(prescale_q);
      REG_COUNT:    rd_val = count_q;
      REG_COMPARE:  rd_val = compare_q;
      default:      rd_val = 32'd0;
    endcase
  end

  // Next-state: W1C first, then hardware events, then bus writes, so that
  // a match beats a clear while COUNT/CTRL writes beat the hardware update.
  always_comb begin
    pending_d     = pending_q;
    enable_d      = enable_q;
    auto_reload_d = auto_reload_q;
    irq_en_d      = irq_en_q;
    prescale_d    = prescale_q;
    count_d       = count_q;
    compare_d     = compare_q;
    ready_d       = accept;
    rdata_d       = accept ? rd_val : 32'd0;

    if (!enable_q || tick) begin
      pre_cnt_d = '0;
    end else begin
      pre_cnt_d = pre_cnt_q + PRESCALE_WIDTH'(1);
    end

    if (wr_en && (reg_idx == REG_IRQ) && bus.mem_wen[0] && bus.mem_wdata[0]) begin
      pending_d = 1'b0;
    end

    if (tick) begin
      if (count_q == compare_q) begin
        pending_d = 1'b1;
        if (auto_reload_q) begin
          count_d = 32'd0;
        end else begin
          enable_d = 1'b0;
        end
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    if (wr_en) begin
      case (reg_idx)
        REG_CTRL: begin
          if (bus.mem_wen[0]) begin
            {irq_en_d, auto_reload_d, enable_d} = bus.mem_wdata[2:0];
          end
        end
        REG_PRESCALE: begin
          prescale_d = PRESCALE_WIDTH'(merge_bytes(32'(prescale_q),
                                                   bus.mem_wdata, bus.mem_wen));
          pre_cnt_d  = '0;
        end
        REG_COUNT:   count_d   = merge_bytes(count_q, bus.mem_wdata, bus.mem_wen);
        REG_COMPARE: compare_d = merge_bytes(compare_q, bus.mem_wdata, bus.mem_wen);
        default: ;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pending_q     <= 1'b0;
      enable_q      <= 1'b0;
      auto_reload_q <= 1'b0;
      irq_en_q      <= 1'b0;
      prescale_q    <= '0;
      pre_cnt_q     <= '0;
      count_q       <= 32'd0;
      compare_q     <= 32'd0;
      ready_q       <= 1'b0;
      rdata_q       <= 32'd0;
    end else begin
      pending_q     <= pending_d;
      enable_q      <= enable_d;
      auto_reload_q <= auto_reload_d;
      irq_en_q      <= irq_en_d;
      prescale_q    <= prescale_d;
      pre_cnt_q     <= pre_cnt_d;
      count_q       <= count_d;
      compare_q     <= compare_d;
      ready_q       <= ready_d;
      rdata_q       <= rdata_d;
    end
  end

endmodule
`default_nettype wire
